btb_predictor: RTL

- Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
- Looks up the fetch PC in the same cycle and drives btb_target_pc, btb_pc_valid and btb_pc_predictTaken into the next-PC select logic in fetch.
- Learns from resolved branches and jumps reported by the execute stage through a single update port.
- Supplies the prediction half of the fetch redirect path; execute supplies the resolution half.

---
 rtl/btb_predictor.sv | 112 +++++++++++
 1 files changed

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Lookup is combinational from the registered table so the
// fetch stage gets a prediction in the same cycle as the PC; the execute
// stage trains the table through a single update port.
module btb_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        btb_pc_valid,
  output logic        btb_pc_predictTaken,
  output logic [31:0] btb_target_pc,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken
);

  localparam int ENTRIES  = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // Saturating increment: never wraps past strong-taken.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    case (c)
      2'b11:   ctr_inc = 2'b11;
      default: ctr_inc = c + 2'b01;
    endcase
  endfunction

  // Saturating decrement: never wraps past strong-not-taken.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    case (c)
      2'b00:   ctr_dec = 2'b00;
      default: ctr_dec = c - 2'b01;
    endcase
  endfunction

  logic                valid_r  [ENTRIES];
  logic [TAG_BITS-1:0] tag_r    [ENTRIES];
  logic [31:0]         target_r [ENTRIES];
  logic [1:0]          ctr_r    [ENTRIES];

  logic [INDEX_BITS-1:0] lu_idx_s;
  logic [TAG_BITS-1:0]   lu_tag_s;
  logic                  lu_hit_s;
  logic [INDEX_BITS-1:0] up_idx_s;
  logic [TAG_BITS-1:0]   up_tag_s;
  logic                  up_hit_s;

  // The byte offset within a word never takes part in indexing or tagging.
  logic unused_offset_s;
  assign unused_offset_s = ^{pc[1:0], update_pc[1:0]};

  // Split both PCs into index/tag and resolve hits against the current table.
  always_comb begin
    lu_idx_s = pc[INDEX_BITS+1:2];
    lu_tag_s = pc[31:INDEX_BITS+2];
    up_idx_s = update_pc[INDEX_BITS+1:2];
    up_tag_s = update_pc[31:INDEX_BITS+2];
    lu_hit_s = valid_r[lu_idx_s] && (tag_r[lu_idx_s] == lu_tag_s);
    up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
  end

  // Prediction outputs; a miss drives all-zero so next-PC select sees no X.
  always_comb begin
    btb_pc_valid        = 1'b0;
    btb_pc_predictTaken = 1'b0;
    btb_target_pc       = 32'h0000_0000;
    if (lu_hit_s) begin
      btb_pc_valid        = 1'b1;
      btb_pc_predictTaken = ctr_r[lu_idx_s][1];
      btb_target_pc       = target_r[lu_idx_s];
    end else begin
      btb_pc_valid        = 1'b0;
      btb_pc_predictTaken = 1'b0;
      btb_target_pc       = 32'h0000_0000;
    end
  end

  // Table training; reset wins over a same-cycle update, no read bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'h0000_0000;
        ctr_r[i]    <= CTR_RESET;
      end
    end else if (update_en) begin
      if (up_hit_s) begin
        if (update_taken) begin
          ctr_r[up_idx_s]    <= ctr_inc(ctr_r[up_idx_s]);
          target_r[up_idx_s] <= update_target;
        end else begin
          ctr_r[up_idx_s] <= ctr_dec(ctr_r[up_idx_s]);
        end
      end else if (update_taken) begin
        // Taken miss allocates, evicting whatever aliased into this index.
        valid_r[up_idx_s]  <= 1'b1;
        tag_r[up_idx_s]    <= up_tag_s;
        target_r[up_idx_s] <= update_target;
        ctr_r[up_idx_s]    <= CTR_ALLOC;
      end
    end
  end

endmodule
